// File: rtl/psw_context_ctrl.sv
// psw_context_ctrl: saves/restores the PSW over the W bus into a small LIFO of contexts.
module psw_context_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int DW = $clog2(DEPTH) + 1,
    localparam int AW = (DW > 1) ? DW - 1 : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             save_req,
    input  logic             restore_req,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_drive,
    output logic             psw_enable,
    output logic             psw_latch,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    depth,
    output logic             ovf_err,
    output logic             unf_err,
    input  logic             err_clr
);
    typedef enum logic [1:0] {IDLE, SAVE_RD, RST_WR, DONE} state_t;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);
    state_t state;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [AW-1:0] wr_idx, rd_idx;
    logic full, empty, idle, ovf_set, unf_set;
    assign wr_idx  = AW'(depth);
    assign rd_idx  = wr_idx - AW'(1);
    assign full    = depth == FULL;
    assign empty   = depth == '0;
    assign idle    = state == IDLE;
    // A full save that also carries a restore is redirected, so it is not an overflow.
    assign ovf_set = idle && save_req && full && !restore_req;
    assign unf_set = idle && !save_req && restore_req && empty;
    always_ff @(posedge clk) begin
        if (state == SAVE_RD)
            stack[wr_idx] <= bus_in;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            depth      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            psw_enable <= 1'b0;
            psw_latch  <= 1'b0;
            bus_drive  <= 1'b0;
            bus_out    <= '0;
            ovf_err    <= 1'b0;
            unf_err    <= 1'b0;
        end else begin
            ovf_err <= ovf_set || (ovf_err && !err_clr);
            unf_err <= unf_set || (unf_err && !err_clr);
            unique case (state)
                IDLE: begin
                    if (save_req && !full) begin
                        state      <= SAVE_RD;
                        busy       <= 1'b1;
                        psw_enable <= 1'b1;
                    end else if (restore_req && !empty) begin
                        state     <= RST_WR;
                        busy      <= 1'b1;
                        psw_latch <= 1'b1;
                        bus_drive <= 1'b1;
                        bus_out   <= stack[rd_idx];
                    end
                end
                SAVE_RD: begin
                    state      <= DONE;
                    psw_enable <= 1'b0;
                    depth      <= depth + DW'(1);
                    done       <= 1'b1;
                end
                RST_WR: begin
                    state     <= DONE;
                    psw_latch <= 1'b0;
                    bus_drive <= 1'b0;
                    bus_out   <= '0;
                    depth     <= depth - DW'(1);
                    done      <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psw_context_ctrl.sv
// tb_psw_context_ctrl: randomized and directed checks against a queue-based context-stack model.
module tb_psw_context_ctrl;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int DW = $clog2(DEPTH) + 1;
    logic clk = 1'b0;
    logic reset, save_req, restore_req, err_clr;
    logic [WIDTH-1:0] bus_in, bus_out;
    logic bus_drive, psw_enable, psw_latch, busy, done, ovf_err, unf_err;
    logic [DW-1:0] depth;
    int n_checks = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] q [$];
    int left = 0;
    bit op_save = 1'b0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    psw_context_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
        .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive),
        .psw_enable(psw_enable), .psw_latch(psw_latch), .busy(busy), .done(done),
        .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs follow from the op timeline: op cycle (left==2), then done cycle (left==1).
    task automatic compare_outputs();
        bit op_cyc;
        op_cyc = left == 2;
        chk("busy", busy, left > 0);
        chk("done", done, left == 1);
        chk("psw_enable", psw_enable, op_cyc && op_save);
        chk("psw_latch", psw_latch, op_cyc && !op_save);
        chk("bus_drive", bus_drive, op_cyc && !op_save);
        chk("bus_out", bus_out, (op_cyc && !op_save) ? q[q.size()-1] : '0);
        chk("depth", depth, q.size());
        chk("ovf_err", ovf_err, m_ovf);
        chk("unf_err", unf_err, m_unf);
        chk("excl", psw_enable & psw_latch, 0);
    endtask

    task automatic model_edge();
        bit idle, o_set, u_set;
        idle  = left == 0;
        o_set = idle && save_req && q.size() == DEPTH && !restore_req;
        u_set = idle && !save_req && restore_req && q.size() == 0;
        if (left == 2) begin
            if (op_save) q.push_back(bus_in);
            else void'(q.pop_back());
            left = 1;
        end else if (left == 1) begin
            left = 0;
        end else if (save_req && q.size() < DEPTH) begin
            op_save = 1'b1;
            left = 2;
        end else if (restore_req && q.size() > 0) begin
            op_save = 1'b0;
            left = 2;
        end
        m_ovf = o_set || (m_ovf && !err_clr);
        m_unf = u_set || (m_unf && !err_clr);
    endtask

    task automatic step(input logic s, input logic r, input logic [WIDTH-1:0] d, input logic c);
        @(negedge clk);
        compare_outputs();
        save_req = s;
        restore_req = r;
        bus_in = d;
        err_clr = c;
        model_edge();
    endtask

    task automatic model_reset();
        q.delete();
        left = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        save_req = 1'b0;
        restore_req = 1'b0;
        bus_in = '0;
        err_clr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            compare_outputs();
        end
        reset = 1'b1;
        // Save 16'hABAA then restore it; bus_in is held through the SAVE_RD cycle.
        step(1, 0, 16'hABAA, 0);
        step(0, 0, 16'hABAA, 0);
        step(0, 0, 16'h0000, 0);
        step(0, 1, 16'h0000, 0);
        repeat (3) step(0, 0, 16'h0000, 0);
        // LIFO ordering
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, WIDTH'(i), 0);
            step(0, 0, WIDTH'(i), 0);
            step(0, 0, 16'h0000, 0);
        end
        repeat (3) begin
            step(0, 1, 16'h0000, 0);
            repeat (2) step(0, 0, 16'h0000, 0);
        end
        step(0, 0, 16'h0000, 0);
        // Fill to full, overflow, drain, underflow, clear
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, WIDTH'(16'h1000 + i), 0);
            step(0, 0, WIDTH'(16'h1000 + i), 0);
            step(0, 0, 16'h0000, 0);
        end
        step(1, 0, 16'hDEAD, 0);
        repeat (3) step(0, 0, 16'h0000, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 16'h0000, 0);
            repeat (2) step(0, 0, 16'h0000, 0);
        end
        step(0, 1, 16'h0000, 0);
        repeat (2) step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 1);
        repeat (2) step(0, 0, 16'h0000, 0);
        // Simultaneous requests at depth 2, then requests while busy
        for (int i = 0; i < 2; i++) begin
            step(1, 0, WIDTH'(16'h2000 + i), 0);
            step(0, 0, WIDTH'(16'h2000 + i), 0);
            step(0, 0, 16'h0000, 0);
        end
        step(1, 1, 16'h3333, 0);
        step(1, 1, 16'h3333, 0);
        step(0, 1, 16'h0000, 0);
        repeat (2) step(0, 0, 16'h0000, 0);
        // Async reset in the middle of RST_WR
        step(0, 1, 16'h0000, 0);
        @(negedge clk);
        compare_outputs();
        save_req = 1'b0;
        restore_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_latch", psw_latch, 0);
        chk("rst_drive", bus_drive, 0);
        chk("rst_busy", busy, 0);
        chk("rst_depth", depth, 0);
        chk("rst_bus_out", bus_out, 0);
        model_reset();
        @(negedge clk);
        compare_outputs();
        reset = 1'b1;
        repeat (2) step(0, 0, 16'h0000, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom),
                 $urandom_range(0, 15) == 0);
        step(0, 0, 16'h0000, 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/psw_context_ctrl.md
PSW_CONTEXT_CTRL -- requirements
Module: psw_context_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 16: bus and PSW word width.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of saved-context entries, a power of two.

Ports:
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1: reset is asynchronous and active-low.
REQ-005 The block SHALL have port save_req, input, 1: request to read the PSW off the W bus and push it.
REQ-006 The block SHALL have port restore_req, input, 1: request to pop an entry and write it into the PSW.
REQ-007 The block SHALL have port bus_in, input, WIDTH: current W bus value.
REQ-008 The block SHALL have port bus_out, output, WIDTH: value this block places on the W bus.
REQ-009 The block SHALL have port bus_drive, output, 1: bus_out is valid and owns the W bus.
REQ-010 The block SHALL have port psw_enable, output, 1: commands the PSW to drive its word onto the W bus.
REQ-011 The block SHALL have port psw_latch, output, 1: commands the PSW to load the W bus.
REQ-012 The block SHALL have port busy, output, 1: the block is in a non-IDLE state.
REQ-013 The block SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 The block SHALL have port depth, output, clog2(DEPTH)+1: number of stored entries.
REQ-015 The block SHALL have port ovf_err, output, 1: sticky flag for a save attempted while full.
REQ-016 The block SHALL have port unf_err, output, 1: sticky flag for a restore attempted while empty.
REQ-017 The block SHALL have port err_clr, input, 1: synchronous clear of ovf_err and unf_err.

Function
REQ-018 The FSM SHALL have states IDLE, SAVE_RD, RST_WR and DONE; requests are sampled only in IDLE.
REQ-019 In IDLE, save_req=1 with depth<DEPTH SHALL go to SAVE_RD; otherwise restore_req=1 with depth>0 SHALL go to RST_WR. Save has priority when both are asserted.
REQ-020 SAVE_RD SHALL last exactly one cycle: psw_enable=1 and bus_drive=0. At the ending edge the block SHALL write bus_in to stack[depth], increment depth and go to DONE.
REQ-021 RST_WR SHALL last exactly one cycle: bus_out=stack[depth-1], bus_drive=1 and psw_latch=1. At the ending edge the block SHALL decrement depth and go to DONE.
REQ-022 DONE SHALL last one cycle with done=1, then go to IDLE. done therefore rises 2 cycles after the request is sampled, and busy is high for 2 cycles.
REQ-023 psw_enable and psw_latch SHALL never be 1 in the same cycle.
REQ-024 bus_drive SHALL be 1 only in RST_WR. Whenever bus_drive=0, bus_out SHALL be 0.
REQ-025 A save_req in IDLE with depth==DEPTH SHALL set ovf_err, stay in IDLE, leave depth and the stack unchanged, and not assert done. This applies only when the request is not redirected to a restore.
REQ-026 A restore_req in IDLE with depth==0 and no save_req SHALL set unf_err and otherwise behave as a no-op.
REQ-027 Requests arriving while busy=1 SHALL be ignored; they are not queued and do not set error flags.
REQ-028 err_clr=1 SHALL clear both error flags at the next edge. If an error event occurs in the same cycle, the set SHALL win.
REQ-029 Stack order SHALL be LIFO: the restored value equals the most recently saved value not yet restored.

Reset
REQ-030 While reset=0, the block SHALL immediately force state=IDLE, depth=0, busy=0, done=0, psw_enable=0, psw_latch=0, bus_drive=0, bus_out=0, ovf_err=0 and unf_err=0. Stack contents are don't-care.
REQ-031 Reset asserted mid-SAVE_RD or mid-RST_WR SHALL abort the operation: no depth change and no done pulse.
REQ-032 The first request SHALL be sampled at the first rising edge after reset deasserts.

Verification
REQ-033 Save then restore: bus_in=16'hABAA, pulse save_req -> psw_enable high 1 cycle, done 2 cycles after the request, depth=1. Then pulse restore_req -> bus_out=16'hABAA with psw_latch=1 and bus_drive=1 for 1 cycle, depth=0.
REQ-034 LIFO: save 16'h0001, 16'h0002, 16'h0003, then 3 restores -> bus_out sequence 0003, 0002, 0001.
REQ-035 Overflow and underflow:
- Fill to DEPTH=4, then save_req -> ovf_err=1, no done, depth stays 4.
- Empty the stack, then restore_req -> unf_err=1.
- Pulse err_clr -> both flags 0.
REQ-036 Simultaneous save_req and restore_req with depth=2 -> a save occurs and depth=3. A new request during busy -> ignored, depth unchanged.
REQ-037 Reset mid-op: drive reset=0 during RST_WR -> psw_latch, bus_drive and busy drop without waiting for clk, depth=0, no done pulse.
REQ-038 Exclusivity: over the whole run, psw_enable and psw_latch are never high together.
